// File: rtl/pipe_latch_em_param.sv
// Execute->Memory pipeline register with valid, stall-hold, flush-to-bubble and a
// sticky stall watchdog. Optional event counters are enabled by PIPE_LATCH_STATS_EN.
module pipe_latch_em_param #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_W      = 4,
  parameter int unsigned CTRL_W    = 23,
  parameter int unsigned MAX_STALL = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_e,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_e,
  input  logic [RD_W-1:0]   rd_e,
  input  logic [DATA_W-1:0] alu_e,
  input  logic [DATA_W-1:0] op1_e,
  input  logic [DATA_W-1:0] op2_e,
  input  logic [CTRL_W-1:0] ctrl_e,
  output logic              valid_m,
  output logic [DATA_W-1:0] pc_m,
  output logic [RD_W-1:0]   rd_m,
  output logic [DATA_W-1:0] alu_m,
  output logic [DATA_W-1:0] op1_m,
  output logic [DATA_W-1:0] op2_m,
  output logic [CTRL_W-1:0] ctrl_m,
  output logic              held_m,
`ifdef PIPE_LATCH_STATS_EN
  output logic [31:0]       cnt_retire,
  output logic [31:0]       cnt_stall,
  output logic [31:0]       cnt_flush,
  output logic [31:0]       cnt_bubble,
`endif
  output logic              stall_timeout
);

  localparam int unsigned CNT_W       = 8;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_HELD} state_t;

  state_t state_q, state_d;

  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;

  // Occupancy FSM: tracks whether M holds nothing, a live instruction, or a stalled one.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (stall) begin
      state_d = (state_q == ST_EMPTY) ? ST_EMPTY : ST_HELD;
    end else begin
      state_d = valid_e ? ST_FULL : ST_EMPTY;
    end
  end

  // Datapath and watchdog next values; priority flush > stall > load.
  always_comb begin
    valid_d     = valid_q;
    held_d      = held_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    if (flush) begin
      valid_d     = 1'b0;
      held_d      = 1'b0;
      pc_d        = '0;
      rd_d        = '0;
      alu_d       = '0;
      op1_d       = '0;
      op2_d       = '0;
      ctrl_d      = '0;
      stall_cnt_d = '0;
      timeout_d   = 1'b0;
    end else if (stall) begin
      held_d      = 1'b1;
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + CNT_W'(1);
      if (stall_cnt_d >= STALL_LIMIT) begin
        timeout_d = 1'b1;
      end
    end else begin
      valid_d     = valid_e;
      held_d      = 1'b0;
      pc_d        = pc_e;
      rd_d        = rd_e;
      alu_d       = alu_e;
      op1_d       = op1_e;
      op2_d       = op2_e;
      // A bubble must never carry write-back or store enables into M.
      ctrl_d      = valid_e ? ctrl_e : '0;
      stall_cnt_d = '0;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      pc_q        <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign valid_m       = valid_q;
  assign held_m        = held_q;
  assign pc_m          = pc_q;
  assign rd_m          = rd_q;
  assign alu_m         = alu_q;
  assign op1_m         = op1_q;
  assign op2_m         = op2_q;
  assign ctrl_m        = ctrl_q;
  assign stall_timeout = timeout_q;

`ifdef PIPE_LATCH_STATS_EN
  logic [31:0] retire_q, retire_d;
  logic [31:0] stallc_q, stallc_d;
  logic [31:0] flushc_q, flushc_d;
  logic [31:0] bubble_q, bubble_d;

  // Exactly one event counter advances per edge.
  always_comb begin
    retire_d = retire_q;
    stallc_d = stallc_q;
    flushc_d = flushc_q;
    bubble_d = bubble_q;
    if (flush) begin
      flushc_d = flushc_q + 32'd1;
    end else if (stall) begin
      stallc_d = stallc_q + 32'd1;
    end else if (valid_e) begin
      retire_d = retire_q + 32'd1;
    end else begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  // Event counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
      stallc_q <= '0;
      flushc_q <= '0;
      bubble_q <= '0;
    end else begin
      retire_q <= retire_d;
      stallc_q <= stallc_d;
      flushc_q <= flushc_d;
      bubble_q <= bubble_d;
    end
  end

  assign cnt_retire = retire_q;
  assign cnt_stall  = stallc_q;
  assign cnt_flush  = flushc_q;
  assign cnt_bubble = bubble_q;
`endif

endmodule
